neo_gfx_mem_sched: RTL and testbench

- Scheduler sharing one 64-bit graphics ROM port among four requesters: sprite C-ROM fetch, fix S-ROM fetch, LO ROM lookup, and a low-priority AUX port used by the CPU and the loader.
- Sits between the LSPC-side fetch strobes (PCK1/PCK2 enables, LO ROM address) and the SDRAM controller.
- Captures requests, arbitrates by fixed priority with anti-starvation for AUX, and runs one transaction at a time.
- Returns data with a one-cycle valid pulse per requester.

---
 rtl/neo_gfx_mem_sched.sv | 171 +++++++++++++++++
 tb/tb_neo_gfx_mem_sched.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/neo_gfx_mem_sched.sv
// Graphics ROM port scheduler: C/S/LO fetch strobes plus a level AUX port share one memory port.
// Optional WAIT-state timeout is enabled with NEO_MEMSCHED_TIMEOUT_EN.
module neo_gfx_mem_sched #(
  parameter int AUX_MAX_WAIT = 16,
  parameter int TIMEOUT      = 63
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        PCK1_EN,
  input  logic [26:0] C_ADDR,
  output logic [63:0] C_DATA,
  output logic        C_VALID,
  input  logic        PCK2_EN,
  input  logic [17:0] S_ADDR,
  output logic [15:0] S_DATA,
  output logic        S_VALID,
  input  logic        LO_EN,
  input  logic [15:0] LO_ADDR,
  output logic [7:0]  LO_DATA,
  output logic        LO_VALID,
  input  logic        AUX_REQ,
  input  logic [26:0] AUX_ADDR,
  output logic [15:0] AUX_DATA,
  output logic        AUX_VALID,
  output logic        MEM_REQ,
  output logic [26:0] MEM_ADDR,
  output logic [1:0]  MEM_SEL,
  output logic        MEM_BURST,
  input  logic        MEM_ACK,
  input  logic        MEM_RDY,
  input  logic [63:0] MEM_DOUT,
  output logic [2:0]  OVR,
  output logic        ERR
);
  localparam logic [1:0] SEL_C = 2'd0, SEL_S = 2'd1, SEL_LO = 2'd2, SEL_AUX = 2'd3;
  localparam int AW = $clog2(AUX_MAX_WAIT + 1);
  localparam logic [AW-1:0] AUX_LIM = AW'(AUX_MAX_WAIT);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;
  state_t state;

  logic          pend_c, pend_s, pend_lo;
  logic [26:3]   c_addr_q;
  logic [17:0]   s_addr_q;
  logic [15:0]   lo_addr_q;
  logic [AW-1:0] aux_wait;
  logic          aux_pend, any_pend, grant;
  logic          gnt_c, gnt_s, gnt_lo, gnt_aux;
  logic [1:0]    win;
  logic [26:0]   gnt_addr;
  logic          done;
  logic [63:0]   rd_data;
  logic          unused_ok;

  assign unused_ok = &{1'b0, C_ADDR[2:0]};

  // The VALID cycle masks AUX so a requester still dropping REQ is not re-granted.
  assign aux_pend = AUX_REQ && !AUX_VALID && !((state != S_IDLE) && (MEM_SEL == SEL_AUX));

  always_comb begin
    win      = SEL_C;
    any_pend = 1'b1;
    if (aux_pend && (aux_wait >= AUX_LIM)) win = SEL_AUX;
    else if (pend_c)                       win = SEL_C;
    else if (pend_s)                       win = SEL_S;
    else if (pend_lo)                      win = SEL_LO;
    else if (aux_pend)                     win = SEL_AUX;
    else                                   any_pend = 1'b0;
  end

  assign grant   = (state == S_IDLE) && any_pend;
  assign gnt_c   = grant && (win == SEL_C);
  assign gnt_s   = grant && (win == SEL_S);
  assign gnt_lo  = grant && (win == SEL_LO);
  assign gnt_aux = grant && (win == SEL_AUX);

  always_comb begin
    case (win)
      SEL_C:   gnt_addr = {c_addr_q, 3'b000};
      SEL_S:   gnt_addr = {9'd0, s_addr_q};
      SEL_LO:  gnt_addr = {11'd0, lo_addr_q};
      default: gnt_addr = AUX_ADDR;
    endcase
  end

`ifdef NEO_MEMSCHED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tcnt;
  logic          tmo;
  assign tmo     = (state == S_WAIT) && !MEM_RDY && (tcnt == TW'(TIMEOUT - 1));
  assign done    = (state == S_WAIT) && (MEM_RDY || tmo);
  assign rd_data = MEM_RDY ? MEM_DOUT : 64'd0;
`else
  localparam int unused_timeout = TIMEOUT;
  assign done    = (state == S_WAIT) && MEM_RDY;
  assign rd_data = MEM_DOUT;
  assign ERR     = 1'b0;
`endif

  // A strobe on its own grant edge re-arms with the new address; the grant keeps the old one.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      pend_c <= 1'b0; pend_s <= 1'b0; pend_lo <= 1'b0;
      c_addr_q <= '0; s_addr_q <= '0; lo_addr_q <= '0;
      aux_wait <= '0;
      OVR <= 3'b000;
    end else begin
      if (PCK1_EN) begin
        pend_c <= 1'b1; c_addr_q <= C_ADDR[26:3];
        if (pend_c && !gnt_c) OVR[0] <= 1'b1;
      end else if (gnt_c) pend_c <= 1'b0;
      if (PCK2_EN) begin
        pend_s <= 1'b1; s_addr_q <= S_ADDR;
        if (pend_s && !gnt_s) OVR[1] <= 1'b1;
      end else if (gnt_s) pend_s <= 1'b0;
      if (LO_EN) begin
        pend_lo <= 1'b1; lo_addr_q <= LO_ADDR;
        if (pend_lo && !gnt_lo) OVR[2] <= 1'b1;
      end else if (gnt_lo) pend_lo <= 1'b0;
      if (gnt_aux)                             aux_wait <= '0;
      else if (aux_pend && aux_wait < AUX_LIM) aux_wait <= aux_wait + 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= S_IDLE;
      MEM_REQ <= 1'b0; MEM_ADDR <= '0; MEM_SEL <= '0; MEM_BURST <= 1'b0;
      C_DATA <= '0; S_DATA <= '0; LO_DATA <= '0; AUX_DATA <= '0;
      C_VALID <= 1'b0; S_VALID <= 1'b0; LO_VALID <= 1'b0; AUX_VALID <= 1'b0;
`ifdef NEO_MEMSCHED_TIMEOUT_EN
      tcnt <= '0;
      ERR  <= 1'b0;
`endif
    end else begin
      C_VALID <= 1'b0; S_VALID <= 1'b0; LO_VALID <= 1'b0; AUX_VALID <= 1'b0;
      case (state)
        S_IDLE: if (grant) begin
          MEM_REQ   <= 1'b1;
          MEM_ADDR  <= gnt_addr;
          MEM_SEL   <= win;
          MEM_BURST <= (win == SEL_C);
          state     <= S_ISSUE;
        end
        S_ISSUE: if (MEM_ACK) begin
          MEM_REQ <= 1'b0;
          state   <= S_WAIT;
`ifdef NEO_MEMSCHED_TIMEOUT_EN
          tcnt    <= '0;
`endif
        end
        S_WAIT: begin
          if (done) begin
            case (MEM_SEL)
              SEL_C:   begin C_DATA   <= rd_data;        C_VALID   <= 1'b1; end
              SEL_S:   begin S_DATA   <= rd_data[15:0];  S_VALID   <= 1'b1; end
              SEL_LO:  begin LO_DATA  <= rd_data[7:0];   LO_VALID  <= 1'b1; end
              default: begin AUX_DATA <= rd_data[15:0];  AUX_VALID <= 1'b1; end
            endcase
            state <= S_IDLE;
          end
`ifdef NEO_MEMSCHED_TIMEOUT_EN
          if (tmo) ERR <= 1'b1;
          tcnt <= tcnt + 1'b1;
`endif
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_neo_gfx_mem_sched.sv
// Scoreboard bench for neo_gfx_mem_sched: expected grants and data are queued at stimulus time.
module tb_neo_gfx_mem_sched;
  logic        CLK = 1'b0;
  logic        RESET;
  logic        PCK1_EN, PCK2_EN, LO_EN, AUX_REQ;
  logic [26:0] C_ADDR, AUX_ADDR;
  logic [17:0] S_ADDR;
  logic [15:0] LO_ADDR;
  logic [63:0] C_DATA;
  logic [15:0] S_DATA, AUX_DATA;
  logic [7:0]  LO_DATA;
  logic        C_VALID, S_VALID, LO_VALID, AUX_VALID;
  logic        MEM_REQ, MEM_BURST, MEM_ACK, MEM_RDY;
  logic [26:0] MEM_ADDR;
  logic [1:0]  MEM_SEL;
  logic [63:0] MEM_DOUT;
  logic [2:0]  OVR;
  logic        ERR;

  typedef struct packed {logic [1:0] sel; logic [26:0] addr; logic burst;} txn_t;
  txn_t        exp_txn[$];
  logic [63:0] exp_c[$];
  logic [15:0] exp_s[$], exp_aux[$];
  logic [7:0]  exp_lo[$];

  int n_chk = 0, n_fail = 0, n_valid = 0;
  int rdy_delay = 0, rdy_mode = 0;

  always #10 CLK = ~CLK;

  neo_gfx_mem_sched dut (
    .CLK(CLK), .RESET(RESET),
    .PCK1_EN(PCK1_EN), .C_ADDR(C_ADDR), .C_DATA(C_DATA), .C_VALID(C_VALID),
    .PCK2_EN(PCK2_EN), .S_ADDR(S_ADDR), .S_DATA(S_DATA), .S_VALID(S_VALID),
    .LO_EN(LO_EN), .LO_ADDR(LO_ADDR), .LO_DATA(LO_DATA), .LO_VALID(LO_VALID),
    .AUX_REQ(AUX_REQ), .AUX_ADDR(AUX_ADDR), .AUX_DATA(AUX_DATA), .AUX_VALID(AUX_VALID),
    .MEM_REQ(MEM_REQ), .MEM_ADDR(MEM_ADDR), .MEM_SEL(MEM_SEL), .MEM_BURST(MEM_BURST),
    .MEM_ACK(MEM_ACK), .MEM_RDY(MEM_RDY), .MEM_DOUT(MEM_DOUT), .OVR(OVR), .ERR(ERR)
  );

  function automatic logic [63:0] pat(input logic [26:0] a);
    if (a == 27'h0123450) return 64'h1122334455667788;
    return {5'h1B, a, 5'h0E, a ^ 27'h2A5A5A5};
  endfunction

  function automatic void push_txn(input logic [1:0] sel, input logic [26:0] a);
    txn_t t;
    logic [63:0] d;
    t.sel = sel; t.addr = a; t.burst = (sel == 2'd0);
    exp_txn.push_back(t);
    d = pat(a);
    case (sel)
      2'd0: exp_c.push_back(d);
      2'd1: exp_s.push_back(d[15:0]);
      2'd2: exp_lo.push_back(d[7:0]);
      default: exp_aux.push_back(d[15:0]);
    endcase
  endfunction

  function automatic int outstanding();
    return exp_txn.size() + exp_c.size() + exp_s.size() + exp_lo.size() + exp_aux.size();
  endfunction

  // Memory side: grant order/address checked against the queue, then ACK and RDY.
  initial begin : mem_model
    txn_t t, got;
    logic [26:0] a;
    MEM_ACK = 1'b0; MEM_RDY = 1'b0; MEM_DOUT = '0;
    forever begin
      @(negedge CLK);
      if (MEM_REQ && !RESET) begin
        got = '{sel: MEM_SEL, addr: MEM_ADDR, burst: MEM_BURST};
        n_chk++;
        if (exp_txn.size() == 0) begin
          n_fail++;
          $display("FAIL mem_grant: got sel=%0d addr=%h, required no request", MEM_SEL, MEM_ADDR);
        end else begin
          t = exp_txn.pop_front();
          if (got !== t) begin
            n_fail++;
            $display("FAIL mem_grant: got sel=%0d addr=%h burst=%b, required sel=%0d addr=%h burst=%b",
                     got.sel, got.addr, got.burst, t.sel, t.addr, t.burst);
          end
        end
        a = MEM_ADDR;
        MEM_ACK = 1'b1;
        @(negedge CLK);
        MEM_ACK = 1'b0;
        if (rdy_mode == 0) begin
          repeat (rdy_delay) @(negedge CLK);
          MEM_RDY = 1'b1; MEM_DOUT = pat(a);
          @(negedge CLK);
          MEM_RDY = 1'b0;
        end else if (rdy_mode == 1) begin
          for (int i = 0; i < 100 && !RESET; i++) @(negedge CLK);
          for (int i = 0; i < 100 && RESET; i++) @(negedge CLK);
          MEM_RDY = 1'b1; MEM_DOUT = pat(a);
          @(negedge CLK);
          MEM_RDY = 1'b0;
        end
      end
    end
  end

  // Requester side: every VALID must match the oldest expected datum for that source.
  initial begin : valid_mon
    forever begin
      @(negedge CLK);
      if (C_VALID) begin
        n_chk++; n_valid++;
        if (exp_c.size() == 0) begin n_fail++; $display("FAIL c_valid: got data %h, required no valid", C_DATA); end
        else if (C_DATA !== exp_c[0]) begin n_fail++; $display("FAIL c_data: got %h, required %h", C_DATA, exp_c[0]); void'(exp_c.pop_front()); end
        else void'(exp_c.pop_front());
      end
      if (S_VALID) begin
        n_chk++; n_valid++;
        if (exp_s.size() == 0) begin n_fail++; $display("FAIL s_valid: got data %h, required no valid", S_DATA); end
        else if (S_DATA !== exp_s[0]) begin n_fail++; $display("FAIL s_data: got %h, required %h", S_DATA, exp_s[0]); void'(exp_s.pop_front()); end
        else void'(exp_s.pop_front());
      end
      if (LO_VALID) begin
        n_chk++; n_valid++;
        if (exp_lo.size() == 0) begin n_fail++; $display("FAIL lo_valid: got data %h, required no valid", LO_DATA); end
        else if (LO_DATA !== exp_lo[0]) begin n_fail++; $display("FAIL lo_data: got %h, required %h", LO_DATA, exp_lo[0]); void'(exp_lo.pop_front()); end
        else void'(exp_lo.pop_front());
      end
      if (AUX_VALID) begin
        n_chk++; n_valid++;
        if (exp_aux.size() == 0) begin n_fail++; $display("FAIL aux_valid: got data %h, required no valid", AUX_DATA); end
        else if (AUX_DATA !== exp_aux[0]) begin n_fail++; $display("FAIL aux_data: got %h, required %h", AUX_DATA, exp_aux[0]); void'(exp_aux.pop_front()); end
        else void'(exp_aux.pop_front());
      end
    end
  end

  task automatic drain(input int max_cycles);
    for (int i = 0; i < max_cycles && outstanding() != 0; i++) @(negedge CLK);
    repeat (2) @(negedge CLK);
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    PCK1_EN = 0; PCK2_EN = 0; LO_EN = 0; AUX_REQ = 0;
    C_ADDR = '0; S_ADDR = '0; LO_ADDR = '0; AUX_ADDR = '0;
    repeat (3) @(negedge CLK);
    n_chk++;
    if ({MEM_REQ, MEM_ADDR, MEM_SEL, MEM_BURST} !== '0) begin
      n_fail++; $display("FAIL reset_mem: got req=%b addr=%h sel=%0d burst=%b, required all 0", MEM_REQ, MEM_ADDR, MEM_SEL, MEM_BURST);
    end
    n_chk++;
    if ({C_DATA, S_DATA, LO_DATA, AUX_DATA} !== '0) begin
      n_fail++; $display("FAIL reset_data: got c=%h s=%h lo=%h aux=%h, required 0", C_DATA, S_DATA, LO_DATA, AUX_DATA);
    end
    n_chk++;
    if ({C_VALID, S_VALID, LO_VALID, AUX_VALID, OVR, ERR} !== '0) begin
      n_fail++; $display("FAIL reset_flags: got valids=%b ovr=%b err=%b, required 0",
                         {C_VALID, S_VALID, LO_VALID, AUX_VALID}, OVR, ERR);
    end
    RESET = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_single_c();
    int lat = -1;
    push_txn(2'd0, 27'h0123450);
    PCK1_EN = 1'b1; C_ADDR = 27'h0123457;
    @(posedge CLK); #1;
    PCK1_EN = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge CLK); #1;
      if (k == 1) begin
        n_chk++;
        if ({MEM_REQ, MEM_ADDR, MEM_SEL, MEM_BURST} !== {1'b1, 27'h0123450, 2'd0, 1'b1}) begin
          n_fail++; $display("FAIL c_issue: got req=%b addr=%h sel=%0d burst=%b, required 1 0123450 0 1",
                             MEM_REQ, MEM_ADDR, MEM_SEL, MEM_BURST);
        end
      end
      if (C_VALID) begin lat = k; break; end
    end
    n_chk++;
    if (lat !== 3) begin n_fail++; $display("FAIL c_latency: got %0d, required 3", lat); end
    @(negedge CLK);
    drain(50);
    n_chk++;
    if (C_DATA !== 64'h1122334455667788) begin n_fail++; $display("FAIL c_hold: got %h, required 1122334455667788", C_DATA); end
  endtask

  task automatic test_priority();
    int last = -1;
    push_txn(2'd0, 27'h0456788);
    push_txn(2'd1, 27'h002ABCD);
    push_txn(2'd2, 27'h0000077);
    push_txn(2'd3, 27'h5ABCDE1);
    PCK1_EN = 1; C_ADDR = 27'h0456789;
    PCK2_EN = 1; S_ADDR = 18'h2ABCD;
    LO_EN = 1;   LO_ADDR = 16'h0077;
    @(negedge CLK);
    PCK1_EN = 0; PCK2_EN = 0; LO_EN = 0;
    AUX_REQ = 1; AUX_ADDR = 27'h5ABCDE1;
    for (int i = 0; i < 60 && (outstanding() != 0 || AUX_REQ); i++) begin
      @(negedge CLK);
      if (C_VALID) last = 0;
      if (S_VALID) last = 1;
      if (LO_VALID) last = 2;
      if (AUX_VALID) begin last = 3; AUX_REQ = 0; end
    end
    n_chk++;
    if (last !== 3 || AUX_REQ !== 1'b0) begin n_fail++; $display("FAIL prio_last: got last=%0d aux_req=%b, required 3 0", last, AUX_REQ); end
    drain(20);
    n_chk++;
    if (outstanding() != 0) begin n_fail++; $display("FAIL prio_drain: got %0d outstanding, required 0", outstanding()); end
  endtask

  task automatic test_starvation();
    int nc = 1, aux_pos = -1, c_grants = 0;
    rdy_delay = 4;
    push_txn(2'd0, 27'h0200000);
    push_txn(2'd0, 27'h0200008);
    push_txn(2'd0, 27'h0200010);
    push_txn(2'd3, 27'h0001234);
    push_txn(2'd0, 27'h0200018);
    PCK1_EN = 1; C_ADDR = 27'h0200000;
    @(negedge CLK);
    PCK1_EN = 0;
    AUX_REQ = 1; AUX_ADDR = 27'h0001234;
    for (int i = 0; i < 200 && (outstanding() != 0 || AUX_REQ); i++) begin
      @(negedge CLK);
      PCK1_EN = 0;
      if (AUX_VALID) AUX_REQ = 0;
      if (MEM_REQ && MEM_SEL == 2'd3) aux_pos = c_grants;
      if (MEM_REQ && MEM_SEL == 2'd0) begin
        c_grants++;
        if (AUX_REQ && nc < 4) begin
          PCK1_EN = 1; C_ADDR = 27'h0200000 + 27'(nc * 8); nc++;
        end
      end
    end
    PCK1_EN = 0;
    n_chk++;
    if (aux_pos !== 3) begin n_fail++; $display("FAIL starve_aux_pos: got %0d C grants before AUX, required 3", aux_pos); end
    drain(40);
    n_chk++;
    if (outstanding() != 0) begin n_fail++; $display("FAIL starve_drain: got %0d outstanding, required 0", outstanding()); end
    rdy_delay = 0;
  endtask

  task automatic test_overrun();
    rdy_delay = 6;
    push_txn(2'd0, 27'h0300000);
    push_txn(2'd1, 27'h0000020);
    PCK1_EN = 1; C_ADDR = 27'h0300000;
    @(negedge CLK);
    PCK1_EN = 0;
    for (int i = 0; i < 10 && !MEM_REQ; i++) @(negedge CLK);
    for (int i = 0; i < 10 && MEM_REQ; i++) @(negedge CLK);
    PCK2_EN = 1; S_ADDR = 18'h00010;
    @(negedge CLK);
    S_ADDR = 18'h00020;
    @(negedge CLK);
    PCK2_EN = 0;
    drain(50);
    n_chk++;
    if (OVR !== 3'b010) begin n_fail++; $display("FAIL ovr_flag: got %b, required 010", OVR); end
    n_chk++;
    if (outstanding() != 0) begin n_fail++; $display("FAIL ovr_drain: got %0d outstanding, required 0", outstanding()); end
    rdy_delay = 0;
  endtask

  task automatic test_reset_wait();
    txn_t t;
    int v0;
    rdy_mode = 1;
    t.sel = 2'd0; t.addr = 27'h0400000; t.burst = 1'b1;
    exp_txn.push_back(t);
    PCK1_EN = 1; C_ADDR = 27'h0400000;
    @(negedge CLK);
    PCK1_EN = 0;
    for (int i = 0; i < 10 && !MEM_REQ; i++) @(negedge CLK);
    for (int i = 0; i < 10 && MEM_REQ; i++) @(negedge CLK);
    @(negedge CLK);
    v0 = n_valid;
    RESET = 1;
    #1;
    n_chk++;
    if ({MEM_REQ, MEM_ADDR, OVR} !== '0) begin
      n_fail++; $display("FAIL rst_wait_out: got req=%b addr=%h ovr=%b, required 0", MEM_REQ, MEM_ADDR, OVR);
    end
    repeat (3) @(negedge CLK);
    RESET = 0;
    repeat (6) @(negedge CLK);
    n_chk++;
    if (n_valid !== v0) begin n_fail++; $display("FAIL rst_wait_valid: got %0d valids, required 0", n_valid - v0); end
    rdy_mode = 0;
    push_txn(2'd1, 27'h0000123);
    PCK2_EN = 1; S_ADDR = 18'h00123;
    @(negedge CLK);
    PCK2_EN = 0;
    drain(30);
    n_chk++;
    if (outstanding() != 0) begin n_fail++; $display("FAIL rst_after_fetch: got %0d outstanding, required 0", outstanding()); end
  endtask

  task automatic test_back_to_back();
    int kv = -1, kr = -1;
    logic prev;
    push_txn(2'd1, 27'h000AAAA);
    push_txn(2'd1, 27'h0015555);
    PCK2_EN = 1; S_ADDR = 18'h0AAAA;
    @(negedge CLK);
    S_ADDR = 18'h15555;
    @(negedge CLK);
    PCK2_EN = 0;
    prev = MEM_REQ;
    for (int k = 1; k <= 20 && kr < 0; k++) begin
      @(posedge CLK); #1;
      if (S_VALID && kv < 0) kv = k;
      if (MEM_REQ && !prev && kv > 0) kr = k;
      prev = MEM_REQ;
    end
    @(negedge CLK);
    n_chk++;
    if (kv < 0 || kr !== kv + 1) begin n_fail++; $display("FAIL b2b_issue: got req at %0d valid at %0d, required req one after valid", kr, kv); end
    drain(30);
    n_chk++;
    if (OVR !== 3'b000) begin n_fail++; $display("FAIL b2b_ovr: got %b, required 000", OVR); end
  endtask

`ifdef NEO_MEMSCHED_TIMEOUT_EN
  task automatic test_timeout();
    int k = 0;
    rdy_mode = 2;
    exp_txn.push_back('{sel: 2'd2, addr: 27'h0000091, burst: 1'b0});
    exp_lo.push_back(8'h00);
    LO_EN = 1; LO_ADDR = 16'h0091;
    @(posedge CLK); #1;
    LO_EN = 0;
    for (int i = 0; i < 10 && !MEM_REQ; i++) begin @(posedge CLK); #1; end
    for (int i = 0; i < 10 && MEM_REQ; i++) begin @(posedge CLK); #1; end
    for (k = 1; k <= 100; k++) begin
      @(posedge CLK); #1;
      if (LO_VALID) break;
    end
    n_chk++;
    if (k !== 63) begin n_fail++; $display("FAIL tmo_cycles: got %0d, required 63", k); end
    n_chk++;
    if (ERR !== 1'b1 || LO_DATA !== 8'h00) begin n_fail++; $display("FAIL tmo_err: got err=%b data=%h, required 1 00", ERR, LO_DATA); end
    @(negedge CLK);
    rdy_mode = 0;
  endtask
`endif

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, outstanding=%0d", outstanding());
    $fatal(1, "watchdog");
  end

  initial begin
    RESET = 1'b1;
    @(negedge CLK);
    test_reset();
    test_single_c();
    test_priority();
    test_starvation();
    test_overrun();
    test_reset_wait();
    test_back_to_back();
`ifdef NEO_MEMSCHED_TIMEOUT_EN
    test_timeout();
`else
    n_chk++;
    if (ERR !== 1'b0) begin n_fail++; $display("FAIL err_tied: got %b, required 0", ERR); end
`endif
    n_chk++;
    if (outstanding() != 0) begin n_fail++; $display("FAIL final_drain: got %0d outstanding, required 0", outstanding()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
